// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic int unsigned digit_cycles(int unsigned width, int unsigned digit);
    return width / digit;
  endfunction

  // Counter spans N digit cycles; a single-cycle operation still gets one bit.
  function automatic int unsigned count_width(int unsigned width, int unsigned digit);
    int unsigned n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit width_ok(int unsigned width, int unsigned digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit combinational full adder; chained DIGIT times per clock by serial_adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic carry
);

  assign s     = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands consumed LSB-first, DIGIT bits per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = digit_cycles(WIDTH, DIGIT);
  localparam int unsigned CntW = count_width(WIDTH, DIGIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : gen_width_check
    $error("serial_adder: WIDTH must be a nonzero multiple of DIGIT");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [DIGIT:0]    chain;
  logic [DIGIT-1:0]  digit_sum;
  logic [WIDTH-1:0]  acc_shift;

  assign chain[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : gen_cells
    full_adder_cell u_cell (
      .a     (opa_q[i]),
      .b     (opb_q[i]),
      .c     (chain[i]),
      .s     (digit_sum[i]),
      .carry (chain[i+1])
    );
  end

  // New digit enters at the top so the accumulator is LSB-aligned after N shifts.
  assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = chain[DIGIT];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = acc_shift;
          cout_d  = chain[DIGIT];
          ovf_d   = chain[DIGIT-1] ^ chain[DIGIT];
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit/2-digit instance plus a 1-bit/1-digit instance.
module tb_serial_adder;

  logic clk;
  logic reset;

  logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic       start1, sub1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8),
    .ovf   (ovf8)
  );

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .sub   (sub1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .ovf   (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                      output logic [7:0] rs, output logic rc, output logic ro, output int lat);
    logic [7:0] prev;
    logic       stable;
    bit         got;
    @(negedge clk);
    prev = sum8;
    sub8 = s; a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check("busy_after_start", busy8, 1);
    stable = (sum8 === prev);
    got = 0;
    lat = -1;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        got = 1;
        lat = k;
      end else if (sum8 !== prev) begin
        stable = 1'b0;
      end
    end
    rs = sum8; rc = cout8; ro = ovf8;
    check("sum_hold_during_run", stable, 1);
    check("busy_during_done", busy8, 1);
    @(posedge clk);
    @(negedge clk);
    check("idle_after_done", {busy8, done8}, 0);
  endtask

  task automatic run1(input logic av, input logic bv, input logic ci,
                      output logic rs, output logic rc, output logic ro, output int lat);
    bit got;
    @(negedge clk);
    sub1 = 1'b0; a1 = av; b1 = bv; cin1 = ci; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    got = 0;
    lat = -1;
    if (done1) begin
      got = 1;
      lat = 0;
    end
    for (int k = 1; k <= 6 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done1) begin
        got = 1;
        lat = k;
      end
    end
    rs = sum1[0]; rc = cout1; ro = ovf1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc, ro, r1s, r1c, r1o;
    int         lat;
    int         dcyc[$];
    int         dcount;
    bit         got;

    checks = 0;
    failures = 0;

    vecs[0]  = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};

    reset = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy8, done8, cout8, ovf8, sum8}, 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run8(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, ro, lat);
      check($sformatf("vec%0d_sum", i), rs, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), rc, vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), ro, vecs[i].ovf);
      check($sformatf("vec%0d_latency", i), lat, 4);
    end

    // start held high: one acceptance every N+2 = 6 cycles
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        dcyc.push_back(c);
        check("held_sum", sum8, 8'h96);
      end
    end
    start8 = 1'b0;
    repeat (8) @(negedge clk);
    check("held_done_count", dcyc.size(), 3);
    check("held_first_done", (dcyc.size() > 0) ? dcyc[0] : -1, 4);
    for (int i = 1; i < dcyc.size(); i++) check("held_interval", dcyc[i] - dcyc[i-1], 6);

    // operands changed during RUN must not disturb the result
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; cin8 = 1'b1;
    got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) got = 1;
    end
    check("chg_done_seen", got, 1);
    check("chg_sum", sum8, 8'h96);
    check("chg_cout", cout8, 0);
    check("chg_ovf", ovf8, 1);

    // start pulsed while in DONE is ignored
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check("done_start_ignored_busy", busy8, 0);
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) dcount++;
    end
    check("done_start_ignored_nodone", dcount, 0);
    check("done_start_ignored_sum", sum8, 8'h96);

    // asynchronous reset mid-RUN aborts without done
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async_outputs", {busy8, done8, cout8, ovf8, sum8}, 0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) dcount++;
    end
    check("reset_no_done", dcount, 0);
    run8(1'b0, 8'h01, 8'h02, 1'b0, rs, rc, ro, lat);
    check("post_reset_sum", rs, 8'h03);
    check("post_reset_latency", lat, 4);

    // 1-bit instance, exhaustive full-adder behaviour
    for (int i = 0; i < 8; i++) begin
      logic ea, eb, ec;
      ea = i[2]; eb = i[1]; ec = i[0];
      run1(ea, eb, ec, r1s, r1c, r1o, lat);
      check($sformatf("w1_%0d_sum", i), r1s, ea ^ eb ^ ec);
      check($sformatf("w1_%0d_cout", i), r1c, (ea & eb) | (ea & ec) | (eb & ec));
      check($sformatf("w1_%0d_ovf", i), r1o, ec ^ ((ea & eb) | (ea & ec) | (eb & ec)));
      check($sformatf("w1_%0d_latency", i), lat, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
